// File: rtl/d_operand_unit.sv
// d_operand_unit: decode-stage operand block for the 5-stage MIPS pipeline.
// Holds the F/D pipeline register and the general register file, resolves
// rs/rt through NFWD priority-ordered forwarding channels, raises its own
// load-use / not-ready stall and keeps a saturating count of stalled cycles.
// Optional macro REG_BYPASS_EN: a same-cycle W-stage write becomes visible
// to the D-stage read (write-through). Without it the array value is
// returned and the W stage must be supplied as a forwarding channel.
module d_operand_unit #(
  parameter int          W        = 32,
  parameter int          AW       = 5,
  parameter int          NFWD     = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Reg_Rst,
  input  logic                We,
  input  logic [31:0]         IR_in,
  input  logic [31:0]         PC_in,
  input  logic                use_a1,
  input  logic                use_a2,
  input  logic                rf_we,
  input  logic [AW-1:0]       rf_a3,
  input  logic [W-1:0]        rf_wd,
  input  logic [NFWD-1:0]     fwd_we,
  input  logic [NFWD-1:0]     fwd_ready,
  input  logic [NFWD*AW-1:0]  fwd_a3,
  input  logic [NFWD*W-1:0]   fwd_wd,
  output logic [31:0]         IR_out,
  output logic [31:0]         PC_out,
  output logic [W-1:0]        RD1_out,
  output logic [W-1:0]        RD2_out,
  output logic                stall,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int DEPTH = 2 ** AW;

  logic [31:0]      ir_p0;
  logic [31:0]      pc_p0;
  logic [CNT_W-1:0] stall_cnt_p0;
  logic [W-1:0]     rf [DEPTH];

  logic [AW-1:0]    a1;
  logic [AW-1:0]    a2;
  logic [W:0]       res1;
  logic [W:0]       res2;
  logic             pend1;
  logic             pend2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Resolve one read port; result is {pending, data}. The first matching
  // channel decides: a not-ready match blocks older channels and the array.
  function automatic logic [W:0] resolve(input logic [AW-1:0] addr);
    logic         hit;
    logic [W:0]   r;
    hit = 1'b0;
    r   = '0;
    if (addr != '0) begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fwd_we[i] && (fwd_a3[i*AW +: AW] == addr)) begin
          hit = 1'b1;
          if (fwd_ready[i]) r = {1'b0, fwd_wd[i*W +: W]};
          else              r = {1'b1, {W{1'b0}}};
        end
      end
      if (!hit) begin
`ifdef REG_BYPASS_EN
        if (rf_we && (rf_a3 == addr)) r = {1'b0, rf_wd};
        else                          r = {1'b0, rf[addr]};
`else
        r = {1'b0, rf[addr]};
`endif
      end
    end
    return r;
  endfunction

  assign a1 = ir_p0[21 +: AW];
  assign a2 = ir_p0[16 +: AW];

  // Combinational operand resolution and stall generation.
  always_comb begin
    res1  = resolve(a1);
    res2  = resolve(a2);
    pend1 = res1[W];
    pend2 = res2[W];
  end

  assign RD1_out   = res1[W-1:0];
  assign RD2_out   = res2[W-1:0];
  assign stall     = (pend1 && use_a1) || (pend2 && use_a2);
  assign IR_out    = ir_p0;
  assign PC_out    = pc_p0;
  assign stall_cnt = stall_cnt_p0;

  // ---- F/D boundary: flush inserts a nop carrying its PC, stall holds ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ir_p0 <= '0;
      pc_p0 <= RESET_PC;
    end else if (Reg_Rst) begin
      ir_p0 <= '0;
      pc_p0 <= PC_in;
    end else if (We && !stall) begin
      ir_p0 <= IR_in;
      pc_p0 <= PC_in;
    end
  end

  // Register file write from W stage; $0 is never written.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (rf_we && (rf_a3 != '0)) begin
      rf[rf_a3] <= rf_wd;
    end
  end

  // Saturating stalled-cycle counter, cleared only by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)        stall_cnt_p0 <= '0;
    else if (stall) stall_cnt_p0 <= sat_inc(stall_cnt_p0);
  end

endmodule

// File: tb/tb_d_operand_unit.sv
// Directed bench for d_operand_unit: reset, register file read/write,
// forwarding priority and stall, flush, counter saturation, write bypass.
module tb_d_operand_unit;

  localparam int W = 32;
  localparam int AW = 5;
  localparam int NFWD = 2;
  localparam int CNT_W = 16;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Reg_Rst;
  logic              We;
  logic [31:0]       IR_in;
  logic [31:0]       PC_in;
  logic              use_a1;
  logic              use_a2;
  logic              rf_we;
  logic [AW-1:0]     rf_a3;
  logic [W-1:0]      rf_wd;
  logic [NFWD-1:0]   fwd_we;
  logic [NFWD-1:0]   fwd_ready;
  logic [NFWD*AW-1:0] fwd_a3;
  logic [NFWD*W-1:0] fwd_wd;
  logic [31:0]       IR_out;
  logic [31:0]       PC_out;
  logic [W-1:0]      RD1_out;
  logic [W-1:0]      RD2_out;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad = 0;

  d_operand_unit #(.W(W), .AW(AW), .NFWD(NFWD), .RESET_PC(32'h0000_3000), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Reg_Rst(Reg_Rst), .We(We), .IR_in(IR_in), .PC_in(PC_in),
    .use_a1(use_a1), .use_a2(use_a2), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .fwd_we(fwd_we), .fwd_ready(fwd_ready), .fwd_a3(fwd_a3), .fwd_wd(fwd_wd),
    .IR_out(IR_out), .PC_out(PC_out), .RD1_out(RD1_out), .RD2_out(RD2_out),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; Reg_Rst = 1'b0; We = 1'b0; IR_in = '0; PC_in = '0;
    use_a1 = 1'b0; use_a2 = 1'b0; rf_we = 1'b0; rf_a3 = '0; rf_wd = '0;
    fwd_we = '0; fwd_ready = '0; fwd_a3 = '0; fwd_wd = '0;
    step(); step();
    Rst = 1'b0;
    #1;
    chk("rst_ir", IR_out, 32'h0);
    chk("rst_pc", PC_out, 32'h0000_3000);
    chk("rst_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);

    // Write $8 while loading an instruction that reads rs=8.
    rf_we = 1'b1; rf_a3 = 5'd8; rf_wd = 32'h1234;
    We = 1'b1; IR_in = 32'h0100_0000; PC_in = 32'h3004;
    step();
    rf_we = 1'b0; We = 1'b0; use_a1 = 1'b1;
    #1;
    chk("ld_ir", IR_out, 32'h0100_0000);
    chk("ld_pc", PC_out, 32'h3004);
    chk("rf_rd8", RD1_out, 32'h1234);

    // Write to $0 is discarded; rs=0 reads 0, rt=8 still reads $8.
    rf_we = 1'b1; rf_a3 = 5'd0; rf_wd = 32'hFFFF;
    We = 1'b1; IR_in = 32'h0008_0000; PC_in = 32'h3008;
    step();
    rf_we = 1'b0; We = 1'b0;
    #1;
    chk("rd_r0", RD1_out, 32'h0);
    chk("rd_rt8", RD2_out, 32'h1234);

    // rs=9: channel 0 not ready blocks ready channel 1.
    use_a1 = 1'b0;
    We = 1'b1; IR_in = 32'h0120_0000; PC_in = 32'h3008;
    step();
    fwd_we = 2'b11; fwd_a3 = {5'd9, 5'd9}; fwd_ready = 2'b10;
    fwd_wd = {32'd7, 32'd0}; use_a1 = 1'b1;
    IR_in = 32'hDEAD_BEEF; PC_in = 32'h300C; We = 1'b1;
    #1;
    chk("stall_prio", {31'h0, stall}, 32'h1);
    step();
    chk("hold_ir", IR_out, 32'h0120_0000);
    chk("hold_pc", PC_out, 32'h3008);
    chk("cnt1", {16'h0, stall_cnt}, 32'd1);
    step();
    chk("cnt2", {16'h0, stall_cnt}, 32'd2);
    fwd_ready = 2'b11; fwd_wd = {32'd7, 32'hA};
    #1;
    chk("unstall", {31'h0, stall}, 32'h0);
    chk("fwd0_data", RD1_out, 32'hA);
    step();
    chk("resume_ir", IR_out, 32'hDEAD_BEEF);
    chk("resume_pc", PC_out, 32'h300C);

    // Pending on an unused port never stalls; flush overrides stall.
    use_a1 = 1'b0; fwd_ready = 2'b10;
    IR_in = 32'h0120_0000; PC_in = 32'h3010; We = 1'b1;
    step();
    We = 1'b0;
    #1;
    chk("unused_nostall", {31'h0, stall}, 32'h0);
    use_a1 = 1'b1;
    #1;
    chk("used_stall", {31'h0, stall}, 32'h1);
    Reg_Rst = 1'b1; We = 1'b1; PC_in = 32'h3014; IR_in = 32'h1111_1111;
    step();
    Reg_Rst = 1'b0; We = 1'b0;
    #1;
    chk("flush_ir", IR_out, 32'h0);
    chk("flush_pc", PC_out, 32'h3014);
    chk("flush_stall", {31'h0, stall}, 32'h0);
    chk("cnt3", {16'h0, stall_cnt}, 32'd3);

    // lw $8,4($0) stalls on rt=8 until counter reaches 5, then async reset.
    use_a1 = 1'b0; fwd_we = '0;
    We = 1'b1; IR_in = 32'h8C08_0004; PC_in = 32'h3018;
    step();
    We = 1'b0; fwd_we = 2'b01; fwd_a3 = {5'd0, 5'd8}; fwd_ready = 2'b00; use_a2 = 1'b1;
    step(); step();
    chk("cnt5", {16'h0, stall_cnt}, 32'd5);
    chk("lw_ir", IR_out, 32'h8C08_0004);
    #3;
    Rst = 1'b1;
    #1;
    chk("arst_ir", IR_out, 32'h0);
    chk("arst_pc", PC_out, 32'h0000_3000);
    chk("arst_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("arst_rd1", RD1_out, 32'h0);
    chk("arst_rd2", RD2_out, 32'h0);
    chk("arst_stall", {31'h0, stall}, 32'h0);
    #1;
    Rst = 1'b0;

    // Same-cycle W write to $10 while D reads rt=10.
    fwd_we = '0; use_a2 = 1'b1;
    We = 1'b1; IR_in = 32'h000A_0000; PC_in = 32'h301C;
    step();
    We = 1'b0;
    rf_we = 1'b1; rf_a3 = 5'd10; rf_wd = 32'h55;
    #1;
`ifdef REG_BYPASS_EN
    chk("bypass_rd2", RD2_out, 32'h55);
`else
    chk("nobypass_rd2", RD2_out, 32'h0);
`endif
    step();
    rf_we = 1'b0;
    #1;
    chk("after_wr_rd2", RD2_out, 32'h55);

    // Long stall: counter counts then sticks at all-ones.
    fwd_we = 2'b01; fwd_a3 = {5'd0, 5'd10}; fwd_ready = 2'b00;
    for (int i = 0; i < 10; i++) step();
    chk("cnt10", {16'h0, stall_cnt}, 32'd10);
    for (int i = 10; i < (1 << CNT_W) + 3; i++) step();
    chk("cnt_sat", {16'h0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_stall", {31'h0, stall}, 32'h1);
    step();
    chk("cnt_nowrap", {16'h0, stall_cnt}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_operand_unit.md
Name: d_operand_unit

Overview:
- Parametrised decode-stage operand block for the 5-stage MIPS pipeline.
- Holds the F/D pipeline register and the general register file.
- Resolves rs/rt operands across NFWD priority-ordered forwarding channels.
- Generates the load-use/not-ready stall itself instead of relying on an external hazard unit, and counts stalled cycles for performance debug.

Parameters:
W, 32, data/register width
AW, 5, register address width; file depth 2^AW
NFWD, 2, number of forwarding channels; channel 0 = youngest stage (E), highest priority
RESET_PC, 32'h0000_3000, PC_out value after reset
CNT_W, 16, stall counter width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-high reset
Reg_Rst  in  1  synchronous flush of F/D register (bubble insert)
We  in  1  F/D register load enable from controller
IR_in  in  32  instruction from F
PC_in  in  32  PC from F
use_a1  in  1  current D instruction reads rs
use_a2  in  1  current D instruction reads rt
rf_we  in  1  W-stage register write enable
rf_a3  in  AW  W-stage write address
rf_wd  in  W  W-stage write data
fwd_we  in  NFWD  channel i writes a register
fwd_ready  in  NFWD  channel i data valid this cycle
fwd_a3  in  NFWD*AW  channel i destination, slice i
fwd_wd  in  NFWD*W  channel i data, slice i
IR_out  out  32  D-stage instruction
PC_out  out  32  D-stage PC
RD1_out  out  W  resolved rs operand
RD2_out  out  W  resolved rt operand
stall  out  1  D must hold; downstream inserts bubble
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clk/Rst are the only clock and reset; Rst asynchronous, active-high.
- On Rst (async, immediate): IR_out=0, PC_out=RESET_PC, all 2^AW registers=0, stall_cnt=0.
- F/D register, rising edge, priority order:
  - Reg_Rst: IR_out<=0 (nop); PC_out<=PC_in so the bubble carries its PC.
  - else We && !stall: IR_out<=IR_in, PC_out<=PC_in.
  - else hold.
  - Reg_Rst overrides stall.
- Read addresses: A1=IR_out[25:21], A2=IR_out[20:16].
- Operand resolution, per port, combinational, first match wins:
  1. addr==0 -> 0.
  2. Lowest i with fwd_we[i] && fwd_a3[i]==addr:
     - if fwd_ready[i] -> fwd_wd[i];
     - else port pending; output don't-care.
     - Never fall through to an older channel past a matching not-ready one.
  3. Bypass path: see REG_BYPASS_EN.
  4. Register array.
- stall = (pending1 && use_a1) || (pending2 && use_a2), combinational, no latency. Pending on an unused port never stalls.
- Register write, rising edge: rf_we && rf_a3!=0 writes rf_wd. Address 0 is never written and always reads 0.
- Simultaneous F/D load and register write in the same edge: both take effect.
- stall_cnt:
  - +1 on each rising edge with stall=1.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by Rst.
- Reset mid-stall: all state clears at once; stall re-evaluates on the cleared IR (nop -> 0).

Optional Feature:
- REG_BYPASS_EN defined: when no forwarding channel matches and rf_we && rf_a3==addr && addr!=0, the read returns rf_wd combinationally (write-through).
- Undefined: same-cycle write is not visible; reads return the old array value. The W-stage must then be supplied as a forwarding channel.

Test Plan:
- Rst asserted mid-cycle with IR_out=32'h8C08_0004, stall_cnt=5 -> immediately IR_out=0, PC_out=32'h3000, stall_cnt=0, RD1_out=RD2_out=0.
- Write $8=32'h1234 (rf_we=1, rf_a3=8), then IR with rs=8, use_a1=1, no fwd match -> RD1_out=32'h1234. Write to $0 with 32'hFFFF -> reading $0 returns 0.
- rs=9, fwd0 (we=1, a3=9, ready=0), fwd1 (we=1, a3=9, ready=1, wd=7), use_a1=1 -> stall=1, IR/PC held. Then fwd0 ready=1, wd=32'hA -> stall=0, RD1_out=32'hA, next We edge loads IR_in.
- Same as previous but use_a1=0 -> stall=0. Reg_Rst=1 with stall=1 -> IR_out=0 next edge, PC_out=PC_in.
- Hold stall=1 for 2^CNT_W+3 cycles -> stall_cnt stays at 16'hFFFF.
- Same cycle: rf_we=1, rf_a3=10, rf_wd=32'h55; D reads rt=10, no fwd match:
  - with REG_BYPASS_EN -> RD2_out=32'h55;
  - without -> RD2_out=old value 0.
